// File: rtl/pbus_router.sv
// Registered address router: decodes each CPU access against NSLV base/mask windows, strobes one
// slave until it is ready or times out, and records the first unacknowledged fault as a sticky irq.
module pbus_router #(
   parameter int                 NSLV     = 4,
   parameter logic [NSLV*32-1:0] SLV_BASE = {32'hf0000000, 32'h92000000, 32'h20000000, 32'h10000000},
   parameter logic [NSLV*32-1:0] SLV_MASK = {32'hf0000000, 32'hff000000, 32'hf0000000, 32'hf0000000},
   parameter int                 TIMEOUT  = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          a,
   input  logic [31:0]          d,
   input  logic                 we,
   input  logic                 rd,
   output logic [31:0]          spo,
   output logic                 ready,
   output logic [NSLV*32-1:0]   s_a,
   output logic [NSLV*32-1:0]   s_d,
   output logic [NSLV-1:0]      s_we,
   output logic [NSLV-1:0]      s_rd,
   input  logic [NSLV*32-1:0]   s_spo,
   input  logic [NSLV-1:0]      s_ready,
   input  logic                 err_clr,
   output logic [31:0]          err_addr,
   output logic [1:0]           err_cause,
   output logic                 irq
);
   localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_t;

   state_t          r_state;
   logic [SW-1:0]   r_sel;
   logic [TW-1:0]   r_tcnt;
   logic [31:0]     r_spo;
   logic [31:0]     r_err_addr;
   logic            r_ready;
   logic [NSLV-1:0] r_s_we;
   logic [NSLV-1:0] r_s_rd;
   logic [1:0]      r_err_cause;

   logic            w_hit;
   logic [SW-1:0]   w_sel;
   logic            w_sready;
   logic [31:0]     w_sspo;
   logic [1:0]      w_err_code;

   for (genvar i = 0; i < NSLV; i++) begin : g_slot
      assign s_a[32*i +: 32] = a & ~SLV_MASK[32*i +: 32];
      assign s_d[32*i +: 32] = d;
   end

   // Descending scan so the lowest matching window is the one left in w_sel.
   always_comb begin
      w_hit = 1'b0;
      w_sel = '0;
      for (int i = NSLV - 1; i >= 0; i--) begin
         if ((a & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
            w_hit = 1'b1;
            w_sel = SW'(i);
         end
      end
   end

   assign w_sready = s_ready[r_sel];
   assign w_sspo   = s_spo[32*r_sel +: 32];

   // A slave answering on the timeout edge wins, so only a silent slave can time out.
   always_comb begin
      w_err_code = 2'b00;
      if (r_state == ST_IDLE) begin
         if (rd && we)
            w_err_code = 2'b11;
         else if ((rd || we) && !w_hit)
            w_err_code = 2'b01;
      end else if (r_state == ST_ACCESS && !w_sready && r_tcnt == TW'(TIMEOUT)) begin
         w_err_code = 2'b10;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_sel       <= '0;
         r_tcnt      <= '0;
         r_spo       <= '0;
         r_ready     <= 1'b0;
         r_s_we      <= '0;
         r_s_rd      <= '0;
         r_err_addr  <= '0;
         r_err_cause <= 2'b00;
      end else begin
         r_ready <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_err_code != 2'b00) begin
                  r_spo   <= '0;
                  r_ready <= 1'b1;
                  r_state <= ST_DONE;
               end else if (rd || we) begin
                  r_sel   <= w_sel;
                  r_tcnt  <= '0;
                  r_s_we  <= NSLV'(we) << w_sel;
                  r_s_rd  <= NSLV'(rd) << w_sel;
                  r_state <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               if (w_sready || w_err_code == 2'b10) begin
                  r_spo   <= w_sready ? w_sspo : 32'h0;
                  r_s_we  <= '0;
                  r_s_rd  <= '0;
                  r_ready <= 1'b1;
                  r_state <= ST_DONE;
               end else begin
                  r_tcnt <= r_tcnt + TW'(1);
               end
            end
            default: r_state <= ST_IDLE;
         endcase

         // First fault sticks; a clear in the same cycle as a new fault lets the new one in.
         if (w_err_code != 2'b00 && (r_err_cause == 2'b00 || err_clr)) begin
            r_err_cause <= w_err_code;
            r_err_addr  <= a;
         end else if (err_clr) begin
            r_err_cause <= 2'b00;
         end
      end
   end

   assign spo       = r_spo;
   assign ready     = r_ready;
   assign s_we      = r_s_we;
   assign s_rd      = r_s_rd;
   assign err_addr  = r_err_addr;
   assign err_cause = r_err_cause;
   assign irq       = (r_err_cause != 2'b00);

endmodule

// File: tb/tb_pbus_router.sv
// Bench for pbus_router: directed scenarios plus randomized transactions scored against a
// transaction-level model of window decode, latency, timeout and sticky error capture.
module tb_pbus_router;
   localparam int NSLV = 4;
   localparam int TMO  = 4;

   logic clk = 1'b0;
   logic rst;
   logic [31:0] a, d;
   logic we, rd, err_clr;
   logic [NSLV*32-1:0] s_spo;
   logic [NSLV-1:0]    s_ready;

   logic [31:0] spo_a, err_addr_a, spo_b, err_addr_b;
   logic ready_a, irq_a, ready_b, irq_b;
   logic [1:0] err_cause_a, err_cause_b;
   logic [NSLV*32-1:0] s_a_a, s_d_a, s_a_b, s_d_b;
   logic [NSLV-1:0] s_we_a, s_rd_a, s_we_b, s_rd_b;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] m_base [NSLV] = '{32'h10000000, 32'h20000000, 32'h92000000, 32'hf0000000};
   logic [31:0] m_mask [NSLV] = '{32'hf0000000, 32'hf0000000, 32'hff000000, 32'hf0000000};

   always #5 clk = ~clk;

   pbus_router #(.NSLV(NSLV), .TIMEOUT(TMO)) u_dut_a (
      .clk(clk), .rst(rst), .a(a), .d(d), .we(we), .rd(rd), .spo(spo_a), .ready(ready_a),
      .s_a(s_a_a), .s_d(s_d_a), .s_we(s_we_a), .s_rd(s_rd_a), .s_spo(s_spo), .s_ready(s_ready),
      .err_clr(err_clr), .err_addr(err_addr_a), .err_cause(err_cause_a), .irq(irq_a)
   );

   // Overlapping windows: slot 1 (0x2/f0) and slot 2 (0x20/ff) both cover 0x20xxxxxx.
   pbus_router #(
      .NSLV(NSLV), .TIMEOUT(TMO),
      .SLV_BASE({32'hf0000000, 32'h20000000, 32'h20000000, 32'h10000000}),
      .SLV_MASK({32'hf0000000, 32'hff000000, 32'hf0000000, 32'hf0000000})
   ) u_dut_b (
      .clk(clk), .rst(rst), .a(a), .d(d), .we(we), .rd(rd), .spo(spo_b), .ready(ready_b),
      .s_a(s_a_b), .s_d(s_d_b), .s_we(s_we_b), .s_rd(s_rd_b), .s_spo(s_spo), .s_ready(s_ready),
      .err_clr(err_clr), .err_addr(err_addr_b), .err_cause(err_cause_b), .irq(irq_b)
   );

   function automatic int decode(input logic [31:0] addr);
      for (int i = 0; i < NSLV; i++)
         if ((addr & m_mask[i]) == m_base[i]) return i;
      return -1;
   endfunction

   task automatic do_reset();
      rst = 1'b1; a = '0; d = '0; we = 1'b0; rd = 1'b0; err_clr = 1'b0; s_spo = '0; s_ready = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; a = 32'h10000010; d = 32'hCAFEF00D; rd = 1'b1; we = 1'b0; err_clr = 1'b0;
      s_spo = '1; s_ready = '1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_vec++;
      if ({spo_a, ready_a, s_we_a, s_rd_a, err_addr_a, err_cause_a, irq_a} !== '0) begin
         n_err++;
         $display("FAIL reset_a: spo=%h ready=%b we=%b rd=%b eaddr=%h cause=%b irq=%b, expected all 0",
                  spo_a, ready_a, s_we_a, s_rd_a, err_addr_a, err_cause_a, irq_a);
      end
      n_vec++;
      if ({spo_b, ready_b, s_we_b, s_rd_b, err_addr_b, err_cause_b, irq_b} !== '0) begin
         n_err++;
         $display("FAIL reset_b: ready=%b we=%b rd=%b cause=%b, expected all 0", ready_b, s_we_b, s_rd_b, err_cause_b);
      end
      n_vec++;
      if (s_a_a[31:0] !== 32'h00000010 || s_a_a[95:64] !== 32'h00000010 || s_d_a[127:96] !== 32'hCAFEF00D) begin
         n_err++;
         $display("FAIL reset_sa: s_a0=%h s_a2=%h s_d3=%h, expected 00000010 00000010 cafef00d",
                  s_a_a[31:0], s_a_a[95:64], s_d_a[127:96]);
      end
      rd = 1'b0; s_spo = '0; s_ready = '0;
      rst = 1'b0;
   endtask

   task automatic test_read_zero_wait();
      @(negedge clk);
      a = 32'h10000010; rd = 1'b1; s_ready = '0; s_spo = '0; s_spo[31:0] = 32'h12345678;
      @(negedge clk);
      n_vec++;
      if (s_rd_a !== 4'b0001 || s_we_a !== 4'b0000 || ready_a !== 1'b0 || s_a_a[31:0] !== 32'h10) begin
         n_err++;
         $display("FAIL rd0_cyc1: s_rd=%b s_we=%b ready=%b s_a0=%h, expected 0001 0000 0 00000010",
                  s_rd_a, s_we_a, ready_a, s_a_a[31:0]);
      end
      s_ready = 4'b0001;
      @(negedge clk);
      n_vec++;
      if (ready_a !== 1'b1 || spo_a !== 32'h12345678 || s_rd_a !== 4'b0000) begin
         n_err++;
         $display("FAIL rd0_cyc2: ready=%b spo=%h s_rd=%b, expected 1 12345678 0000", ready_a, spo_a, s_rd_a);
      end
      rd = 1'b0; s_ready = '0;
      @(negedge clk);
      n_vec++;
      if (ready_a !== 1'b0 || s_rd_a !== 4'b0000) begin
         n_err++;
         $display("FAIL rd0_cyc3: ready=%b s_rd=%b, expected 0 0000", ready_a, s_rd_a);
      end
   endtask

   task automatic test_write_wait();
      int cnt, rcyc;
      cnt = 0; rcyc = 0;
      @(negedge clk);
      a = 32'h92000004; d = 32'h000000A5; we = 1'b1; s_ready = 4'b1011;
      for (int c = 1; c <= 12 && rcyc == 0; c++) begin
         @(negedge clk);
         if (ready_a === 1'b1) begin
            rcyc = c;
         end else begin
            if (s_we_a === 4'b0100) cnt++;
            n_vec++;
            if (s_rd_a !== 4'b0000 || (s_we_a & 4'b1011) !== 4'b0000 ||
                s_d_a[95:64] !== 32'hA5 || s_a_a[95:64] !== 32'h4) begin
               n_err++;
               $display("FAIL wr_strobes c=%0d: s_we=%b s_rd=%b s_d2=%h s_a2=%h, expected only slot 2, a5, 4",
                        c, s_we_a, s_rd_a, s_d_a[95:64], s_a_a[95:64]);
            end
            s_ready = (c == 4) ? 4'b0100 : 4'b1011;
         end
      end
      n_vec++;
      if (cnt !== 4 || rcyc !== 5 || s_we_a !== 4'b0000) begin
         n_err++;
         $display("FAIL wr_latency: strobe cycles=%0d ready cycle=%0d s_we=%b, expected 4 5 0000", cnt, rcyc, s_we_a);
      end
      we = 1'b0; s_ready = '0;
   endtask

   task automatic test_unmapped();
      @(negedge clk);
      a = 32'h50000000; rd = 1'b1;
      @(negedge clk);
      n_vec++;
      if (ready_a !== 1'b1 || spo_a !== 32'h0 || err_cause_a !== 2'b01 || err_addr_a !== 32'h50000000 ||
          irq_a !== 1'b1 || s_rd_a !== 4'b0000) begin
         n_err++;
         $display("FAIL unmapped: ready=%b spo=%h cause=%b eaddr=%h irq=%b s_rd=%b, expected 1 0 01 50000000 1 0000",
                  ready_a, spo_a, err_cause_a, err_addr_a, irq_a, s_rd_a);
      end
      rd = 1'b0;
      @(negedge clk);
      a = 32'h10000000; rd = 1'b1; we = 1'b1;
      @(negedge clk);
      n_vec++;
      if (ready_a !== 1'b1 || s_rd_a !== 4'b0000 || s_we_a !== 4'b0000 ||
          err_cause_a !== 2'b01 || err_addr_a !== 32'h50000000) begin
         n_err++;
         $display("FAIL second_fault: ready=%b s_rd=%b s_we=%b cause=%b eaddr=%h, expected 1 0000 0000 01 50000000",
                  ready_a, s_rd_a, s_we_a, err_cause_a, err_addr_a);
      end
      rd = 1'b0; we = 1'b0;
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      n_vec++;
      if (err_cause_a !== 2'b00 || irq_a !== 1'b0) begin
         n_err++;
         $display("FAIL err_clr: cause=%b irq=%b, expected 00 0", err_cause_a, irq_a);
      end
   endtask

   task automatic test_timeout();
      int cnt, rcyc;
      cnt = 0; rcyc = 0;
      @(negedge clk);
      a = 32'h20000000; rd = 1'b1; s_ready = 4'b1101; s_spo = '1;
      for (int c = 1; c <= 15 && rcyc == 0; c++) begin
         @(negedge clk);
         if (ready_a === 1'b1) rcyc = c;
         else if (s_rd_a === 4'b0010) cnt++;
      end
      n_vec++;
      if (cnt !== TMO + 1 || rcyc !== TMO + 2 || spo_a !== 32'h0 || err_cause_a !== 2'b10 ||
          err_addr_a !== 32'h20000000 || s_rd_a !== 4'b0000) begin
         n_err++;
         $display("FAIL timeout: strobe=%0d ready cyc=%0d spo=%h cause=%b eaddr=%h, expected %0d %0d 0 10 20000000",
                  cnt, rcyc, spo_a, err_cause_a, err_addr_a, TMO + 1, TMO + 2);
      end
      rd = 1'b0; s_ready = '0; s_spo = '0;
   endtask

   task automatic test_overlap();
      do_reset();
      @(negedge clk);
      a = 32'h20000040; rd = 1'b1; s_ready = '0;
      s_spo = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
      @(negedge clk);
      n_vec++;
      if (s_rd_b !== 4'b0010 || s_a_b[63:32] !== 32'h00000040) begin
         n_err++;
         $display("FAIL overlap_sel: s_rd=%b s_a1=%h, expected 0010 00000040", s_rd_b, s_a_b[63:32]);
      end
      s_ready = 4'b0110;
      @(negedge clk);
      n_vec++;
      if (ready_b !== 1'b1 || spo_b !== 32'h11111111) begin
         n_err++;
         $display("FAIL overlap_data: ready=%b spo=%h, expected 1 11111111", ready_b, spo_b);
      end
      rd = 1'b0; s_ready = '0;
   endtask

   task automatic test_rst_abort();
      @(negedge clk);
      a = 32'h10000020; rd = 1'b1; s_ready = '0;
      @(negedge clk);
      n_vec++;
      if (s_rd_a !== 4'b0001) begin
         n_err++;
         $display("FAIL abort_start: s_rd=%b, expected 0001", s_rd_a);
      end
      rst = 1'b1;
      @(negedge clk);
      n_vec++;
      if ({s_rd_a, s_we_a, ready_a} !== '0) begin
         n_err++;
         $display("FAIL abort_rst: s_rd=%b s_we=%b ready=%b, expected 0", s_rd_a, s_we_a, ready_a);
      end
      rst = 1'b0; rd = 1'b0; s_ready = '1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_vec++;
         if ({s_rd_a, ready_a} !== '0) begin
            n_err++;
            $display("FAIL abort_quiet c=%0d: s_rd=%b ready=%b, expected 0", c, s_rd_a, ready_a);
         end
      end
      s_ready = '0;
      a = 32'h10000000; rd = 1'b1; we = 1'b1;
      @(negedge clk);
      rd = 1'b0; we = 1'b0;
      n_vec++;
      if (ready_a !== 1'b1 || err_cause_a !== 2'b11 || err_addr_a !== 32'h10000000) begin
         n_err++;
         $display("FAIL rdwe_fault: ready=%b cause=%b eaddr=%h, expected 1 11 10000000", ready_a, err_cause_a, err_addr_a);
      end
      @(negedge clk);
      a = 32'h50000004; rd = 1'b1; err_clr = 1'b1;
      @(negedge clk);
      rd = 1'b0; err_clr = 1'b0;
      n_vec++;
      if (ready_a !== 1'b1 || err_cause_a !== 2'b01 || err_addr_a !== 32'h50000004 || irq_a !== 1'b1) begin
         n_err++;
         $display("FAIL clr_and_fault: ready=%b cause=%b eaddr=%h irq=%b, expected 1 01 50000004 1",
                  ready_a, err_cause_a, err_addr_a, irq_a);
      end
   endtask

   task automatic test_random();
      logic [1:0]      m_cause;
      logic [31:0]     m_addr;
      logic [31:0]     ta, td, exp_spo;
      logic            trd, twe, tclr, done;
      logic [NSLV-1:0] exp_str, nz;
      int              op, k, sel, code, ls, rc;
      do_reset();
      m_cause = 2'b00; m_addr = '0;
      for (int t = 0; t < 300; t++) begin
         case ($urandom_range(0, 5))
            0: ta = {4'h1, 28'($urandom)};
            1: ta = {4'h2, 28'($urandom)};
            2: ta = {8'h92, 24'($urandom)};
            3: ta = {4'hf, 28'($urandom)};
            4: ta = {8'h93, 24'($urandom)};
            default: ta = $urandom;
         endcase
         td = $urandom;
         op = $urandom_range(0, 9);
         trd = (op <= 5);
         twe = (op == 0) || (op >= 6);
         k = $urandom_range(0, TMO + 2);
         tclr = ($urandom_range(0, 4) == 0);
         sel = decode(ta);
         if (trd && twe) code = 3;
         else if (sel < 0) code = 1;
         else code = (k > TMO) ? 2 : 0;
         ls = (code == 0 || code == 2) ? ((k > TMO) ? TMO : k) + 1 : 0;
         rc = (ls > 0) ? ls + 1 : 1;
         if (code == 1 || code == 3) begin
            if (m_cause == 2'b00 || tclr) begin m_cause = 2'(code); m_addr = ta; end
         end else if (tclr) begin
            m_cause = 2'b00;
         end
         if (code == 2 && m_cause == 2'b00) begin m_cause = 2'b10; m_addr = ta; end
         exp_spo = 32'h0;
         exp_str = (ls > 0) ? NSLV'(1) << sel : '0;

         @(negedge clk);
         n_vec++;
         if ({ready_a, s_rd_a, s_we_a} !== '0) begin
            n_err++;
            $display("FAIL rnd_idle t=%0d: ready=%b s_rd=%b s_we=%b, expected 0", t, ready_a, s_rd_a, s_we_a);
         end
         a = ta; d = td; rd = trd; we = twe; err_clr = tclr;
         s_spo = {$urandom, $urandom, $urandom, $urandom};
         s_ready = NSLV'($urandom);
         if (sel >= 0) s_ready[sel] = 1'b0;
         done = 1'b0;
         for (int c = 1; c <= TMO + 4 && !done; c++) begin
            @(negedge clk);
            err_clr = 1'b0;
            n_vec++;
            if (s_rd_a !== ((trd && c <= ls) ? exp_str : '0) || s_we_a !== ((twe && c <= ls) ? exp_str : '0) ||
                ready_a !== (c == rc)) begin
               n_err++;
               $display("FAIL rnd_cycle t=%0d c=%0d a=%h: s_rd=%b s_we=%b ready=%b, expected strobe %b to cycle %0d, ready cycle %0d",
                        t, c, ta, s_rd_a, s_we_a, ready_a, exp_str, ls, rc);
            end
            if (c == rc) begin
               n_vec++;
               if (spo_a !== exp_spo || err_cause_a !== m_cause || err_addr_a !== m_addr || irq_a !== (m_cause != 2'b00)) begin
                  n_err++;
                  $display("FAIL rnd_result t=%0d a=%h: spo=%h cause=%b eaddr=%h irq=%b, expected %h %b %h %b",
                           t, ta, spo_a, err_cause_a, err_addr_a, irq_a, exp_spo, m_cause, m_addr, m_cause != 2'b00);
               end
               rd = 1'b0; we = 1'b0; s_ready = '0;
               done = 1'b1;
            end else begin
               s_spo = {$urandom, $urandom, $urandom, $urandom};
               nz = NSLV'($urandom);
               if (sel >= 0) begin
                  nz[sel] = (c == 1 + k) && (code == 0);
                  if (c == 1 + k && code == 0) exp_spo = s_spo[32*sel +: 32];
               end
               s_ready = nz;
            end
         end
         if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL rnd_timeout t=%0d: no ready within %0d cycles", t, TMO + 4);
            rd = 1'b0; we = 1'b0; s_ready = '0;
         end
      end
   endtask

   initial begin
      test_reset();
      test_read_zero_wait();
      test_write_wait();
      test_unmapped();
      test_timeout();
      test_overlap();
      test_rst_abort();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
